// File: rtl/pcie_read_request_arbiter.sv
// ==== pcie_read_request_arbiter : round-robin DMA read-request arbiter with PCIe tag pool and completion steering ====
// ==== Revision 1.0 ====
`timescale 1ns/1ps
`default_nettype none

module pcie_read_request_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int NUM_TAGS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CH-1:0]      req_valid,
    input  logic [64*NUM_CH-1:0]   req_address,
    output logic                   tlp_req_valid,
    input  logic                   tlp_req_ready,
    output logic [63:0]            tlp_req_address,
    output logic [7:0]             tlp_req_tag,
    input  logic                   cpl_valid,
    input  logic [7:0]             cpl_tag,
    input  logic                   cpl_last,
    input  logic [63:0]            cpl_data,
    output logic [NUM_CH-1:0]      ch_cpl_valid,
    output logic [63:0]            ch_cpl_data,
    output logic [5:0]             tags_in_use,
    output logic                   err_overrun,
    output logic                   err_bad_tag
);

    localparam int          C_CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          C_TAG_W     = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam logic [63:0] C_ADDR_MASK = ~64'h1FF;

    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [63:0]         addr_q [NUM_CH];
    logic [63:0]         addr_d [NUM_CH];
    logic [NUM_TAGS-1:0] tag_valid_q, tag_valid_d;
    logic [C_CH_W-1:0]   tag_owner_q [NUM_TAGS];
    logic [C_CH_W-1:0]   tag_owner_d [NUM_TAGS];
    logic [C_CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                tlp_valid_q, tlp_valid_d;
    logic [63:0]         tlp_addr_q, tlp_addr_d;
    logic [7:0]          tlp_tag_q, tlp_tag_d;
    logic [NUM_CH-1:0]   ch_cpl_valid_q, ch_cpl_valid_d;
    logic [63:0]         ch_cpl_data_q, ch_cpl_data_d;
    logic [5:0]          tags_in_use_q, tags_in_use_d;
    logic                err_overrun_q, err_overrun_d;
    logic                err_bad_tag_q, err_bad_tag_d;

    logic                grant_found;
    logic [C_CH_W-1:0]   grant_ch;
    logic                tag_found;
    logic [C_TAG_W-1:0]  grant_tag;
    logic                grant;
    logic [C_TAG_W-1:0]  cpl_idx;
    logic                cpl_good;
    logic                release_tag;

    // Rotating search: first pending channel at or above the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_found && pending_q[C_CH_W'((int'(rr_ptr_q) + k) % NUM_CH)]) begin
                grant_found = 1'b1;
                grant_ch    = C_CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            end
        end
    end

    // Only tags free in the registered table are candidates, so a tag released this cycle waits one cycle.
    always_comb begin
        tag_found = 1'b0;
        grant_tag = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            if (!tag_found && !tag_valid_q[t]) begin
                tag_found = 1'b1;
                grant_tag = C_TAG_W'(t);
            end
        end
    end

    assign grant       = grant_found && tag_found && (!tlp_valid_q || tlp_req_ready);
    assign cpl_idx     = cpl_tag[C_TAG_W-1:0];
    assign cpl_good    = cpl_valid && (cpl_tag < 8'(NUM_TAGS)) && tag_valid_q[cpl_idx];
    assign release_tag = cpl_good && cpl_last;

    always_comb begin
        pending_d      = pending_q;
        addr_d         = addr_q;
        tag_valid_d    = tag_valid_q;
        tag_owner_d    = tag_owner_q;
        rr_ptr_d       = rr_ptr_q;
        tlp_valid_d    = tlp_valid_q;
        tlp_addr_d     = tlp_addr_q;
        tlp_tag_d      = tlp_tag_q;
        ch_cpl_valid_d = '0;
        ch_cpl_data_d  = ch_cpl_data_q;
        tags_in_use_d  = tags_in_use_q;
        err_overrun_d  = err_overrun_q;
        err_bad_tag_d  = cpl_valid && !cpl_good;

        for (int i = 0; i < NUM_CH; i++) begin
            if (req_valid[i]) begin
                if (pending_q[i]) begin
                    err_overrun_d = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    addr_d[i]    = req_address[64*i +: 64];
                end
            end
        end

        if (release_tag) begin
            tag_valid_d[cpl_idx] = 1'b0;
        end

        if (grant) begin
            pending_d[grant_ch]    = 1'b0;
            tag_valid_d[grant_tag] = 1'b1;
            tag_owner_d[grant_tag] = grant_ch;
            rr_ptr_d    = (grant_ch == C_CH_W'(NUM_CH - 1)) ? '0 : grant_ch + C_CH_W'(1);
            tlp_valid_d = 1'b1;
            tlp_addr_d  = addr_q[grant_ch] & C_ADDR_MASK;
            tlp_tag_d   = 8'(grant_tag);
        end else if (tlp_req_ready) begin
            tlp_valid_d = 1'b0;
        end

        if (grant && !release_tag) begin
            tags_in_use_d = tags_in_use_q + 6'd1;
        end else if (release_tag && !grant) begin
            tags_in_use_d = tags_in_use_q - 6'd1;
        end

        if (cpl_good) begin
            ch_cpl_valid_d[tag_owner_q[cpl_idx]] = 1'b1;
            ch_cpl_data_d                        = cpl_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q      <= '0;
            tag_valid_q    <= '0;
            rr_ptr_q       <= '0;
            tlp_valid_q    <= 1'b0;
            tlp_addr_q     <= '0;
            tlp_tag_q      <= '0;
            ch_cpl_valid_q <= '0;
            ch_cpl_data_q  <= '0;
            tags_in_use_q  <= '0;
            err_overrun_q  <= 1'b0;
            err_bad_tag_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i] <= '0;
            end
            for (int t = 0; t < NUM_TAGS; t++) begin
                tag_owner_q[t] <= '0;
            end
        end else begin
            pending_q      <= pending_d;
            addr_q         <= addr_d;
            tag_valid_q    <= tag_valid_d;
            tag_owner_q    <= tag_owner_d;
            rr_ptr_q       <= rr_ptr_d;
            tlp_valid_q    <= tlp_valid_d;
            tlp_addr_q     <= tlp_addr_d;
            tlp_tag_q      <= tlp_tag_d;
            ch_cpl_valid_q <= ch_cpl_valid_d;
            ch_cpl_data_q  <= ch_cpl_data_d;
            tags_in_use_q  <= tags_in_use_d;
            err_overrun_q  <= err_overrun_d;
            err_bad_tag_q  <= err_bad_tag_d;
        end
    end

    assign tlp_req_valid   = tlp_valid_q;
    assign tlp_req_address = tlp_addr_q;
    assign tlp_req_tag     = tlp_tag_q;
    assign ch_cpl_valid    = ch_cpl_valid_q;
    assign ch_cpl_data     = ch_cpl_data_q;
    assign tags_in_use     = tags_in_use_q;
    assign err_overrun     = err_overrun_q;
    assign err_bad_tag     = err_bad_tag_q;

endmodule

`default_nettype wire

// File: tb/tb_pcie_read_request_arbiter.sv
// ==== tb_pcie_read_request_arbiter : directed scoreboard bench for pcie_read_request_arbiter (4 channels, 4 tags) ====
// ==== Revision 1.0 ====
`timescale 1ns/1ps
`default_nettype none

module tb_pcie_read_request_arbiter;

    localparam int NCH = 4;
    localparam int NTG = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   req_valid;
    logic [64*NCH-1:0] req_address;
    logic             tlp_req_valid;
    logic             tlp_req_ready;
    logic [63:0]      tlp_req_address;
    logic [7:0]       tlp_req_tag;
    logic             cpl_valid;
    logic [7:0]       cpl_tag;
    logic             cpl_last;
    logic [63:0]      cpl_data;
    logic [NCH-1:0]   ch_cpl_valid;
    logic [63:0]      ch_cpl_data;
    logic [5:0]       tags_in_use;
    logic             err_overrun;
    logic             err_bad_tag;

    pcie_read_request_arbiter #(.NUM_CH(NCH), .NUM_TAGS(NTG)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_address     (req_address),
        .tlp_req_valid   (tlp_req_valid),
        .tlp_req_ready   (tlp_req_ready),
        .tlp_req_address (tlp_req_address),
        .tlp_req_tag     (tlp_req_tag),
        .cpl_valid       (cpl_valid),
        .cpl_tag         (cpl_tag),
        .cpl_last        (cpl_last),
        .cpl_data        (cpl_data),
        .ch_cpl_valid    (ch_cpl_valid),
        .ch_cpl_data     (ch_cpl_data),
        .tags_in_use     (tags_in_use),
        .err_overrun     (err_overrun),
        .err_bad_tag     (err_bad_tag)
    );

    always #5 clock = ~clock;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  tag;
    } tlp_exp_t;

    typedef struct {
        logic [3:0]  onehot;
        logic [63:0] data;
        int          cyc;
    } cpl_exp_t;

    tlp_exp_t tlp_q[$];
    cpl_exp_t cpl_q[$];
    int       rr2_order[4] = '{2, 3, 0, 1};

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] amask(input logic [63:0] a);
        return {a[63:9], 9'b0};
    endfunction

    function automatic logic [63:0] rr_addr(input int ch, input int round);
        return 64'hAB00_0000 + (64'(round) << 16) + (64'(ch) << 12) + 64'h155;
    endfunction

    task automatic set_addr(input int ch, input logic [63:0] a);
        req_address[64*ch +: 64] = a;
    endtask

    task automatic expect_tlp(input logic [63:0] a, input int tag);
        tlp_exp_t e;
        e.addr = a;
        e.tag  = 8'(tag);
        tlp_q.push_back(e);
    endtask

    // Drives one beat for one cycle; a non-zero onehot means the beat must reach that channel next cycle.
    task automatic send_cpl(input int tag, input logic last, input logic [63:0] data, input logic [3:0] onehot);
        cpl_exp_t e;
        cpl_valid = 1'b1;
        cpl_tag   = 8'(tag);
        cpl_last  = last;
        cpl_data  = data;
        if (onehot != 4'b0) begin
            e.onehot = onehot;
            e.data   = data;
            e.cyc    = cyc + 1;
            cpl_q.push_back(e);
        end
        tick();
        cpl_valid = 1'b0;
        cpl_last  = 1'b0;
    endtask

    always @(negedge clock) begin : monitor
        tlp_exp_t te;
        cpl_exp_t ce;
        if (!reset) begin
            if (tlp_req_valid && tlp_req_ready) begin
                if (tlp_q.size() == 0) begin
                    check("tlp_unexpected", 64'(tlp_req_valid), 64'd0);
                end else begin
                    te = tlp_q.pop_front();
                    check("tlp_addr", tlp_req_address, te.addr);
                    check("tlp_tag", 64'(tlp_req_tag), 64'(te.tag));
                end
            end
            if (ch_cpl_valid != '0) begin
                if (cpl_q.size() == 0) begin
                    check("cpl_unexpected", 64'(ch_cpl_valid), 64'd0);
                end else begin
                    ce = cpl_q.pop_front();
                    check("cpl_onehot", 64'(ch_cpl_valid), 64'(ce.onehot));
                    check("cpl_data", ch_cpl_data, ce.data);
                    check("cpl_latency", 64'(cyc), 64'(ce.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid     = '0;
        req_address   = '0;
        tlp_req_ready = 1'b0;
        cpl_valid     = 1'b0;
        cpl_tag       = '0;
        cpl_last      = 1'b0;
        cpl_data      = '0;

        // Requests during reset must be ignored.
        for (int i = 0; i < NCH; i++) set_addr(i, 64'h7700_0000 + 64'(i));
        req_valid = 4'hF;
        reset = 1'b1;
        repeat (3) tick();
        reset     = 1'b0;
        req_valid = '0;
        check("rst_tlp_valid", 64'(tlp_req_valid), 64'd0);
        check("rst_tlp_addr", tlp_req_address, 64'd0);
        check("rst_tlp_tag", 64'(tlp_req_tag), 64'd0);
        check("rst_ch_cpl_valid", 64'(ch_cpl_valid), 64'd0);
        check("rst_ch_cpl_data", ch_cpl_data, 64'd0);
        check("rst_tags_in_use", 64'(tags_in_use), 64'd0);
        check("rst_err_overrun", 64'(err_overrun), 64'd0);
        check("rst_err_bad_tag", 64'(err_bad_tag), 64'd0);
        repeat (3) tick();
        check("req_in_reset_ignored", 64'(tlp_req_valid), 64'd0);

        // Single request on channel 2, then 64 completion beats.
        tlp_req_ready = 1'b1;
        set_addr(2, 64'h1_2345_6000);
        expect_tlp(64'h1_2345_6000, 0);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        check("single_lat_n1", 64'(tlp_req_valid), 64'd0);
        tick();
        check("single_lat_n2", 64'(tlp_req_valid), 64'd1);
        check("single_addr", tlp_req_address, 64'h1_2345_6000);
        check("single_tag", 64'(tlp_req_tag), 64'd0);
        check("single_tags_in_use", 64'(tags_in_use), 64'd1);
        tick();
        check("single_drop_valid", 64'(tlp_req_valid), 64'd0);
        for (int b = 0; b < 64; b++) begin
            send_cpl(0, (b == 63), {32'hC0DE_0000, 32'(b)}, 4'b0100);
        end
        tick();
        check("single_tags_release", 64'(tags_in_use), 64'd0);
        check("single_cpl_drained", 64'(cpl_q.size()), 64'd0);

        // Round robin from pointer 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            set_addr(i, rr_addr(i, 1));
            expect_tlp(amask(rr_addr(i, 1)), i);
        end
        req_valid = 4'hF;
        tick();
        req_valid = '0;
        tick();
        for (int j = 0; j < NCH; j++) begin
            check("rr1_valid", 64'(tlp_req_valid), 64'd1);
            check("rr1_tag", 64'(tlp_req_tag), 64'(j));
            tick();
        end
        check("rr1_idle", 64'(tlp_req_valid), 64'd0);
        check("rr1_tags_full", 64'(tags_in_use), 64'd4);
        for (int i = 0; i < NTG; i++) begin
            send_cpl(i, 1'b1, 64'hFACE_0000 + 64'(i), 4'(1 << i));
        end
        check("rr1_tags_freed", 64'(tags_in_use), 64'd0);

        // Channel 1 alone moves the pointer to 2.
        set_addr(1, 64'h3_0000_0200);
        expect_tlp(64'h3_0000_0200, 0);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        check("ch1_tag", 64'(tlp_req_tag), 64'd0);
        tick();
        send_cpl(0, 1'b1, 64'h1111_2222_3333_4444, 4'b0010);

        // Round robin from pointer 2.
        for (int i = 0; i < NCH; i++) set_addr(i, rr_addr(i, 2));
        for (int j = 0; j < NCH; j++) expect_tlp(amask(rr_addr(rr2_order[j], 2)), j);
        req_valid = 4'hF;
        tick();
        req_valid = '0;
        tick();
        for (int j = 0; j < NCH; j++) begin
            check("rr2_tag", 64'(tlp_req_tag), 64'(j));
            tick();
        end
        check("rr2_idle", 64'(tlp_req_valid), 64'd0);
        check("rr2_tags_full", 64'(tags_in_use), 64'd4);

        // Exhaustion, release timing and backpressure. Owners: tag0 ch2, tag1 ch3, tag2 ch0, tag3 ch1.
        tlp_req_ready = 1'b0;
        set_addr(0, 64'h5_0000_0000);
        set_addr(3, 64'h5_0000_3000);
        expect_tlp(64'h5_0000_3000, 1);
        expect_tlp(64'h5_0000_0000, 2);
        req_valid = 4'b1001;
        tick();
        req_valid = '0;
        repeat (3) tick();
        check("exhaust_no_grant", 64'(tlp_req_valid), 64'd0);
        check("exhaust_tags", 64'(tags_in_use), 64'd4);
        send_cpl(1, 1'b1, 64'hAAAA_0001, 4'b1000);
        check("release_no_same_cycle", 64'(tlp_req_valid), 64'd0);
        check("release_tags", 64'(tags_in_use), 64'd3);
        tick();
        check("reuse_valid", 64'(tlp_req_valid), 64'd1);
        check("reuse_tag", 64'(tlp_req_tag), 64'd1);
        check("reuse_addr", tlp_req_address, 64'h5_0000_3000);
        send_cpl(2, 1'b1, 64'hAAAA_0002, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            check("bp_hold_addr", tlp_req_address, 64'h5_0000_3000);
            check("bp_hold_tag", 64'(tlp_req_tag), 64'd1);
            tick();
        end
        check("bp_hold_valid", 64'(tlp_req_valid), 64'd1);
        check("bp_tags", 64'(tags_in_use), 64'd3);
        tlp_req_ready = 1'b1;
        tick();
        check("b2b_valid", 64'(tlp_req_valid), 64'd1);
        check("b2b_tag", 64'(tlp_req_tag), 64'd2);
        check("b2b_addr", tlp_req_address, 64'h5_0000_0000);
        tick();
        check("b2b_idle", 64'(tlp_req_valid), 64'd0);

        // Interleaved completions on tag0 (ch2) and tag1 (ch3), then bad tags.
        for (int i = 0; i < 6; i++) begin
            send_cpl(i % 2, (i >= 4), 64'hBEEF_0000_0000_0000 + 64'(i), (i % 2 == 1) ? 4'b1000 : 4'b0100);
        end
        check("ilv_tags", 64'(tags_in_use), 64'd2);
        send_cpl(5, 1'b1, 64'hDEAD_0005, 4'b0000);
        check("badtag5_pulse", 64'(err_bad_tag), 64'd1);
        check("badtag5_no_cpl", 64'(ch_cpl_valid), 64'd0);
        tick();
        check("badtag5_one_cycle", 64'(err_bad_tag), 64'd0);
        send_cpl(0, 1'b1, 64'hDEAD_0000, 4'b0000);
        check("badtag0_pulse", 64'(err_bad_tag), 64'd1);
        check("badtag0_no_cpl", 64'(ch_cpl_valid), 64'd0);
        check("badtag_tags", 64'(tags_in_use), 64'd2);

        // Refill the pool: pointer is 1, so ch2 gets tag0 and ch3 gets tag1.
        set_addr(2, 64'h6_0000_2000);
        set_addr(3, 64'h6_0000_3000);
        expect_tlp(64'h6_0000_2000, 0);
        expect_tlp(64'h6_0000_3000, 1);
        req_valid = 4'b1100;
        tick();
        req_valid = '0;
        tick();
        check("refill_tag0", 64'(tlp_req_tag), 64'd0);
        tick();
        check("refill_tag1", 64'(tlp_req_tag), 64'd1);
        tick();
        check("refill_tags", 64'(tags_in_use), 64'd4);

        // Overrun on channel 0 while starved.
        set_addr(0, 64'h7_0000_0000);
        req_valid = 4'b0001;
        tick();
        set_addr(0, 64'h7_FFFF_F000);
        check("overrun_clear", 64'(err_overrun), 64'd0);
        tick();
        req_valid = '0;
        check("overrun_set", 64'(err_overrun), 64'd1);
        expect_tlp(64'h7_0000_0000, 2);
        send_cpl(2, 1'b1, 64'h0123_4567_89AB_CDEF, 4'b0001);
        tick();
        check("overrun_tag", 64'(tlp_req_tag), 64'd2);
        check("overrun_first_addr", tlp_req_address, 64'h7_0000_0000);
        tick();
        check("overrun_sticky", 64'(err_overrun), 64'd1);

        // Reset with all tags outstanding and a pending request.
        set_addr(1, 64'h8_0000_1000);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 64'(tlp_req_valid), 64'd0);
        check("mid_rst_addr", tlp_req_address, 64'd0);
        check("mid_rst_tag", 64'(tlp_req_tag), 64'd0);
        check("mid_rst_ch_cpl_data", ch_cpl_data, 64'd0);
        check("mid_rst_tags", 64'(tags_in_use), 64'd0);
        check("mid_rst_overrun", 64'(err_overrun), 64'd0);
        repeat (3) tick();
        check("mid_rst_pending_cleared", 64'(tlp_req_valid), 64'd0);
        send_cpl(0, 1'b1, 64'h5555_AAAA, 4'b0000);
        check("post_rst_badtag", 64'(err_bad_tag), 64'd1);
        check("post_rst_no_cpl", 64'(ch_cpl_valid), 64'd0);
        tick();

        check("tlp_sb_empty", 64'(tlp_q.size()), 64'd0);
        check("cpl_sb_empty", 64'(cpl_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
